// File: rtl/spi_pkg.sv
// spi_pkg: command opcodes shared by the SPI slave controller and the RAM behind it
package spi_pkg;
  typedef enum logic [1:0] {
    OP_WR_ADDR = 2'b00,
    OP_WR_DATA = 2'b01,
    OP_RD_ADDR = 2'b10,
    OP_RD_DATA = 2'b11
  } opcode_t;
endpackage

// File: rtl/single_port_ram.sv
// single_port_ram: command-driven single-port RAM behind the SPI slave's serial-to-parallel converter
//   clk      rising-edge clock
//   rst_n    asynchronous active-low reset (clears dout, tx_valid, wr_addr, rd_addr; mem is kept)
//   rx_valid din holds a command word this cycle
//   din      {opcode[1:0], payload[ADDR_WIDTH-1:0]}
//   dout     registered read data
//   tx_valid one-cycle strobe marking fresh read data on dout
module single_port_ram
  import spi_pkg::*;
#(
  parameter int ADDR_WIDTH = 8,
  parameter int MEM_DEPTH  = 256,
  parameter int DATA_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  rx_valid,
  input  logic [ADDR_WIDTH+1:0] din,
  output logic [DATA_WIDTH-1:0] dout,
  output logic                  tx_valid
);
  localparam int IW = MEM_DEPTH > 1 ? $clog2(MEM_DEPTH) : 1;
  localparam logic [ADDR_WIDTH:0] DEPTH = (ADDR_WIDTH + 1)'(MEM_DEPTH);
  logic [DATA_WIDTH-1:0] mem [MEM_DEPTH];
  logic [ADDR_WIDTH-1:0] wr_addr, rd_addr, payload;
  opcode_t op;
  logic wr_en, rd_en, wr_ok, rd_ok;
  assign op      = opcode_t'(din[ADDR_WIDTH+1:ADDR_WIDTH]);
  assign payload = din[ADDR_WIDTH-1:0];
  assign wr_ok   = {1'b0, wr_addr} < DEPTH;
  assign rd_ok   = {1'b0, rd_addr} < DEPTH;
  // rst_n gating keeps an asserted reset from letting a write through on the same edge
  assign wr_en   = rst_n && rx_valid && op == OP_WR_DATA && wr_ok;
  assign rd_en   = rx_valid && op == OP_RD_DATA;
  always_ff @(posedge clk)
    if (wr_en) mem[wr_addr[IW-1:0]] <= payload[DATA_WIDTH-1:0];
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      wr_addr  <= '0;
      rd_addr  <= '0;
      dout     <= '0;
      tx_valid <= 1'b0;
    end else begin
      tx_valid <= rd_en;
      if (rx_valid && op == OP_WR_ADDR) wr_addr <= payload;
      if (rx_valid && op == OP_RD_ADDR) rd_addr <= payload;
      // out-of-range reads still strobe, but return zero
      if (rd_en) dout <= rd_ok ? mem[rd_addr[IW-1:0]] : '0;
    end
endmodule

// File: tb/tb_single_port_ram.sv
// tb_single_port_ram: randomized self-checking bench for single_port_ram with a full-depth and a shallow instance
module tb_single_port_ram;
  localparam int SD = 16;
  logic clk = 1'b0, rst_n = 1'b0, rx_valid = 1'b0;
  logic [9:0] din = '0;
  logic [7:0] dout, dout_s;
  logic tx_valid, tx_valid_s;
  int compared = 0, mismatched = 0;
  logic [7:0] ref_mem [256];
  logic [7:0] ref_mem_s [SD];
  logic [7:0] ref_wa = '0, ref_ra = '0, ref_dout = '0, ref_dout_s = '0;
  logic ref_tx = 1'b0;
  always #5 clk = ~clk;
  single_port_ram dut (
    .clk(clk), .rst_n(rst_n), .rx_valid(rx_valid), .din(din), .dout(dout), .tx_valid(tx_valid)
  );
  single_port_ram #(.MEM_DEPTH(SD)) dut_s (
    .clk(clk), .rst_n(rst_n), .rx_valid(rx_valid), .din(din), .dout(dout_s), .tx_valid(tx_valid_s)
  );
  initial begin
    #1ms;
    $display("FAIL watchdog: simulation time limit reached, got no finish, required finish");
    $fatal(1, "timeout");
  end
  task automatic cycle(input logic v, input logic [9:0] d);
    rx_valid = v;
    din = d;
    @(posedge clk);
    ref_tx = v && d[9:8] == 2'b11;
    if (v)
      case (d[9:8])
        2'b00: ref_wa = d[7:0];
        2'b01: begin
          ref_mem[ref_wa] = d[7:0];
          if (ref_wa < SD) ref_mem_s[ref_wa[3:0]] = d[7:0];
        end
        2'b10: ref_ra = d[7:0];
        default: begin
          ref_dout = ref_mem[ref_ra];
          ref_dout_s = ref_ra < SD ? ref_mem_s[ref_ra[3:0]] : 8'h00;
        end
      endcase
    @(negedge clk);
  endtask
  task automatic preload;
    logic [7:0] v;
    for (int i = 0; i < 256; i++) begin
      v = i == 8'hFF ? 8'hA5 : i == 8'h10 ? 8'h3C : i == 8'h02 ? 8'h5A : 8'($urandom);
      cycle(1'b1, {2'b00, 8'(i)});
      cycle(1'b1, {2'b01, v});
    end
  endtask
  task automatic test_initial_reset;
    compared++;
    if (dout !== 8'h00 || tx_valid !== 1'b0) begin
      mismatched++;
      $display("FAIL initial_reset: dout=%h tx_valid=%b, required dout=00 tx_valid=0", dout, tx_valid);
    end
  endtask
  task automatic test_write_read;
    cycle(1'b1, 10'h02A);
    cycle(1'b1, 10'h15C);
    cycle(1'b1, 10'h22A);
    cycle(1'b1, 10'h300);
    compared++;
    if (dout !== 8'h5C || tx_valid !== 1'b1) begin
      mismatched++;
      $display("FAIL write_read: dout=%h tx_valid=%b, required dout=5c tx_valid=1", dout, tx_valid);
    end
    cycle(1'b0, 10'h300);
    compared++;
    if (dout !== 8'h5C || tx_valid !== 1'b0) begin
      mismatched++;
      $display("FAIL write_read_strobe_end: dout=%h tx_valid=%b, required dout=5c tx_valid=0", dout, tx_valid);
    end
  endtask
  task automatic test_back_to_back;
    cycle(1'b1, 10'h2FF);
    for (int k = 0; k < 2; k++) begin
      cycle(1'b1, {2'b11, 8'($urandom)});
      compared++;
      if (dout !== 8'hA5 || tx_valid !== 1'b1) begin
        mismatched++;
        $display("FAIL back_to_back_%0d: dout=%h tx_valid=%b, required dout=a5 tx_valid=1", k, dout, tx_valid);
      end
      compared++;
      if (dout_s !== 8'h00 || tx_valid_s !== 1'b1) begin
        mismatched++;
        $display("FAIL out_of_range_read_%0d: dout=%h tx_valid=%b, required dout=00 tx_valid=1", k, dout_s, tx_valid_s);
      end
    end
  endtask
  task automatic test_rx_gating;
    cycle(1'b1, 10'h010);
    cycle(1'b0, 10'h177);
    compared++;
    if (dut.mem[8'h10] !== 8'h3C || tx_valid !== 1'b0 || dout !== 8'hA5) begin
      mismatched++;
      $display("FAIL rx_gating: mem[10]=%h tx_valid=%b dout=%h, required mem[10]=3c tx_valid=0 dout=a5", dut.mem[8'h10], tx_valid, dout);
    end
    compared++;
    if (dut_s.mem[4'h0] !== ref_mem_s[0]) begin
      mismatched++;
      $display("FAIL rx_gating_small: mem[0]=%h, required %h", dut_s.mem[4'h0], ref_mem_s[0]);
    end
  endtask
  task automatic test_addr_independence;
    cycle(1'b1, 10'h001);
    cycle(1'b1, 10'h202);
    cycle(1'b1, 10'h111);
    cycle(1'b1, 10'h122);
    compared++;
    if (dut.mem[8'h01] !== 8'h22) begin
      mismatched++;
      $display("FAIL addr_indep_write: mem[1]=%h, required 22", dut.mem[8'h01]);
    end
    cycle(1'b1, 10'h300);
    compared++;
    if (dout !== 8'h5A || tx_valid !== 1'b1) begin
      mismatched++;
      $display("FAIL addr_indep_read: dout=%h tx_valid=%b, required dout=5a tx_valid=1", dout, tx_valid);
    end
    compared++;
    if (dout_s !== 8'h5A) begin
      mismatched++;
      $display("FAIL addr_indep_read_small: dout=%h, required 5a", dout_s);
    end
  endtask
  task automatic test_reset;
    logic [7:0] keep;
    cycle(1'b1, 10'h055);
    keep = ref_mem[8'h55];
    rx_valid = 1'b1;
    din = 10'h1EE;
    #2 rst_n = 1'b0;
    #1;
    compared++;
    if (dout !== 8'h00 || tx_valid !== 1'b0 || dout_s !== 8'h00) begin
      mismatched++;
      $display("FAIL reset_outputs: dout=%h tx_valid=%b dout_s=%h, required 00/0/00", dout, tx_valid, dout_s);
    end
    compared++;
    if (dut.wr_addr !== 8'h00 || dut.rd_addr !== 8'h00) begin
      mismatched++;
      $display("FAIL reset_addrs: wr_addr=%h rd_addr=%h, required 00/00", dut.wr_addr, dut.rd_addr);
    end
    @(posedge clk);
    #1;
    compared++;
    if (dut.mem[8'h55] !== keep || dut.mem[8'hFF] !== 8'hA5) begin
      mismatched++;
      $display("FAIL reset_mem_kept: mem[55]=%h mem[ff]=%h, required %h/a5", dut.mem[8'h55], dut.mem[8'hFF], keep);
    end
    ref_wa = '0;
    ref_ra = '0;
    ref_dout = '0;
    ref_dout_s = '0;
    ref_tx = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    rx_valid = 1'b0;
  endtask
  task automatic test_random;
    logic v;
    logic [9:0] d;
    for (int n = 0; n < 10000; n++) begin
      v = $urandom_range(0, 3) != 0;
      d = 10'($urandom);
      if ($urandom_range(0, 1) == 0) d[7:4] = 4'h0;
      cycle(v, d);
      compared++;
      if (dout !== ref_dout || tx_valid !== ref_tx) begin
        mismatched++;
        $display("FAIL random_%0d: dout=%h tx_valid=%b, required dout=%h tx_valid=%b", n, dout, tx_valid, ref_dout, ref_tx);
      end
      compared++;
      if (dout_s !== ref_dout_s || tx_valid_s !== ref_tx) begin
        mismatched++;
        $display("FAIL random_small_%0d: dout=%h tx_valid=%b, required dout=%h tx_valid=%b", n, dout_s, tx_valid_s, ref_dout_s, ref_tx);
      end
    end
  endtask
  initial begin
    repeat (2) @(negedge clk);
    test_initial_reset;
    rst_n = 1'b1;
    @(negedge clk);
    preload;
    test_write_read;
    test_back_to_back;
    test_rx_gating;
    test_addr_independence;
    test_reset;
    test_random;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule
